toggle_leds_axil_slave: RTL and testbench
=========================================

Name: toggle_leds_axil_slave

Overview:
- AXI4-Lite responder register file for the toggle_leds IP. It answers the single-beat write and read transactions issued by the master VIP or the PS.
- Holds four 32-bit registers and drives a LED toggle engine from them.
- Sits between the interconnect M_AXI port and the board LED pins.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported
C_S_AXI_ADDR_WIDTH, 6, byte address width; regs at 0x00-0x0C, 0x10-0x3C unmapped
NUM_LEDS, 4, width of led_out (1..32)

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESET  in  1  reset (asynchronous assert, active-high)
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake
S_AXI_BRESP  out  2  OKAY=00, SLVERR=10
S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake
led_out  out  NUM_LEDS  LED drive

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: all READY, BVALID and RVALID are 0; BRESP, RRESP and RDATA are 0; all registers are 0; led_out is 0.
- Register map:
  - 0x00 CTRL: [0] enable, [1] clear (self-clearing), rest R/W storage.
  - 0x04 PERIOD: toggle period in cycles.
  - 0x08 PATTERN: LED toggle mask.
  - 0x0C SCRATCH.
  - All four read back exactly the last written value. CTRL[1] always reads 0.
- Write FSM (states W_IDLE, W_RESP):
  - W_IDLE: AWREADY and WREADY are both asserted for one cycle only when AWVALID and WVALID are both high. The write is committed in that same cycle, honouring WSTRB per byte. Go to W_RESP with BVALID=1.
  - Either channel arriving alone is held off (READY stays low) until the other arrives.
  - W_RESP: hold BVALID and BRESP until BREADY, then return to W_IDLE. A new AW/W is accepted no earlier than the cycle after the B handshake.
- Read FSM (states R_IDLE, R_DATA):
  - R_IDLE: ARREADY=1 for one cycle when ARVALID. RDATA and RRESP are registered that cycle. Go to R_DATA with RVALID=1.
  - R_DATA: RDATA is held stable until RREADY.
  - Latency is ARVALID to RVALID of 1 cycle, and AW/W to BVALID of 1 cycle.
- Address decode uses addr[C_S_AXI_ADDR_WIDTH-1:2]. addr[1:0] is ignored.
- Unmapped addresses (0x10 and above): writes have no effect and return BRESP=SLVERR; reads return RDATA=0 and RRESP=SLVERR.
- Simultaneous read and write to the same register in the same cycle: the read returns the pre-write value.
- Toggle engine:
  - The 32-bit counter runs while CTRL[0]=1 and PERIOD != 0.
  - When the counter reaches PERIOD-1 it wraps to 0, and led_out ^= PATTERN[NUM_LEDS-1:0] on that edge.
  - PERIOD=0: no toggling, counter held at 0.
  - CTRL[0]=0: counter reset to 0, led_out holds its value.
  - Writing CTRL[1]=1 clears led_out and the counter in the commit cycle; this takes priority over a toggle in the same cycle.
  - A PERIOD write takes effect immediately. If the counter is already >= the new PERIOD-1, it wraps on the next cycle.
- Reset asserted mid-transaction: all state returns to reset values at once; a pending B or R is dropped.

Decomposition:
- Package toggle_leds_pkg holds:
  - register offset localparams;
  - RESP_OKAY and RESP_SLVERR;
  - a w_state_t/r_state_t enum;
  - a ctrl_t packed struct {reserved[29:0], clear, enable}.
- Sub-module toggle_leds_engine holds the counter and led_out. Its inputs are enable, clear, period and pattern.

Test Plan:
- Sequential writes of 1,2,3,4 to 0x0,0x4,0x8,0xC, then read back -> RDATA 1,2,3,4 (CTRL reads 1), all OKAY.
- AWVALID asserted 3 cycles before WVALID -> AWREADY stays 0 until WVALID. Single commit; BVALID exactly one cycle after the handshake.
- Write 0xAABBCCDD to 0xC with WSTRB=0101 over 0x11223344 -> reads 0x11BB33DD.
- Write/read 0x20 -> BRESP=10, RRESP=10, RDATA=0; registers unchanged.
- PERIOD=4, PATTERN=0xF, CTRL=1 -> led_out is 0xF at cycle 4 and 0x0 at cycle 8. A CTRL=3 write then gives led_out=0. BREADY held low 10 cycles -> BVALID and BRESP stable throughout.
- Assert reset while RVALID is pending -> RVALID=0, led_out=0, and all registers read 0 after release.

Source files
------------

// File: rtl/toggle_leds_pkg.sv
// Shared types and constants for the toggle_leds AXI4-Lite register block.
package toggle_leds_pkg;

  // Register word indices (byte offsets 0x00, 0x04, 0x08, 0x0C)
  localparam logic [1:0] IDX_CTRL    = 2'd0;
  localparam logic [1:0] IDX_PERIOD  = 2'd1;
  localparam logic [1:0] IDX_PATTERN = 2'd2;
  localparam logic [1:0] IDX_SCRATCH = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  typedef struct packed {
    logic [29:0] reserved;
    logic        clear;
    logic        enable;
  } ctrl_t;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/toggle_leds_engine.sv
// Free-running period counter that XORs the pattern into the LEDs on every wrap.
module toggle_leds_engine #(
  parameter int unsigned NUM_LEDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                clear,
  input  logic [31:0]         period,
  input  logic [NUM_LEDS-1:0] pattern,
  output logic [NUM_LEDS-1:0] led_out
);

  logic [31:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      led_out <= '0;
    end else if (clear) begin
      cnt_q   <= '0;
      led_out <= '0;
    end else if (!enable || period == '0) begin
      cnt_q <= '0;
    end else if (cnt_q >= period - 32'd1) begin
      // >= so that shrinking PERIOD below the current count wraps at once
      cnt_q   <= '0;
      led_out <= led_out ^ pattern;
    end else begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

endmodule

// File: rtl/toggle_leds_axil_slave.sv
// AXI4-Lite register file (CTRL/PERIOD/PATTERN/SCRATCH) driving the LED toggle engine.
module toggle_leds_axil_slave
  import toggle_leds_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned NUM_LEDS           = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_LEDS-1:0]             led_out
);

  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;

  ctrl_t       ctrl_q;
  logic [31:0] period_q, pattern_q, scratch_q;
  logic [31:0] rd_val;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;

  logic [C_S_AXI_ADDR_WIDTH-3:0] aw_word, ar_word;
  logic [1:0] aw_idx, ar_idx;
  logic       aw_mapped, ar_mapped;
  logic       wr_en, rd_en, clear_pulse;
  logic       unused;

  assign aw_word   = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign ar_word   = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign aw_idx    = aw_word[1:0];
  assign ar_idx    = ar_word[1:0];
  assign aw_mapped = (aw_word[C_S_AXI_ADDR_WIDTH-3:2] == '0);
  assign ar_mapped = (ar_word[C_S_AXI_ADDR_WIDTH-3:2] == '0);

  // Both write channels are taken together; a lone AW or W waits for its partner
  assign wr_en = (w_state_q == W_IDLE) && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_en = (r_state_q == R_IDLE) && S_AXI_ARVALID;

  assign clear_pulse = wr_en && aw_mapped && (aw_idx == IDX_CTRL) &&
                       S_AXI_WSTRB[0] && S_AXI_WDATA[1];

  assign S_AXI_AWREADY = wr_en;
  assign S_AXI_WREADY  = wr_en;
  assign S_AXI_BVALID  = (w_state_q == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = rd_en;
  assign S_AXI_RVALID  = (r_state_q == R_DATA);
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      W_IDLE: if (wr_en) w_state_d = W_RESP;
      W_RESP: if (S_AXI_BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE: if (rd_en) r_state_d = R_DATA;
      R_DATA: if (S_AXI_RREADY) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    if (ar_mapped) begin
      unique case (ar_idx)
        IDX_CTRL:    rd_val = ctrl_q;
        IDX_PERIOD:  rd_val = period_q;
        IDX_PATTERN: rd_val = pattern_q;
        IDX_SCRATCH: rd_val = scratch_q;
        default:     rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      period_q  <= '0;
      pattern_q <= '0;
      scratch_q <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      if (wr_en) bresp_q <= aw_mapped ? RESP_OKAY : RESP_SLVERR;
      if (wr_en && aw_mapped) begin
        unique case (aw_idx)
          // clear is a strobe, never stored
          IDX_CTRL:    ctrl_q <= ctrl_t'(apply_strb(ctrl_q, S_AXI_WDATA, S_AXI_WSTRB) &
                                         ~32'h2);
          IDX_PERIOD:  period_q  <= apply_strb(period_q, S_AXI_WDATA, S_AXI_WSTRB);
          IDX_PATTERN: pattern_q <= apply_strb(pattern_q, S_AXI_WDATA, S_AXI_WSTRB);
          IDX_SCRATCH: scratch_q <= apply_strb(scratch_q, S_AXI_WDATA, S_AXI_WSTRB);
          default: ;
        endcase
      end
      // Sampled from the current register values, so a same-cycle write is not seen
      if (rd_en) begin
        rdata_q <= rd_val;
        rresp_q <= ar_mapped ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  toggle_leds_engine #(
    .NUM_LEDS(NUM_LEDS)
  ) u_engine (
    .clk     (S_AXI_ACLK),
    .rst     (S_AXI_ARESET),
    .enable  (ctrl_q.enable),
    .clear   (clear_pulse),
    .period  (period_q),
    .pattern (pattern_q[NUM_LEDS-1:0]),
    .led_out (led_out)
  );

  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                    ctrl_q.reserved, ctrl_q.clear, pattern_q};

endmodule

// File: tb/tb_toggle_leds_axil_slave.sv
// Directed plus randomized bench for toggle_leds_axil_slave with a register-map model.
module tb_toggle_leds_axil_slave;
  import toggle_leds_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [3:0]  led;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [4];

  always #5 clk = ~clk;

  toggle_leds_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(6),
    .NUM_LEDS          (4)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .S_AXI_AWADDR (awaddr),
    .S_AXI_AWPROT (awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA  (wdata),
    .S_AXI_WSTRB  (wstrb),
    .S_AXI_WVALID (wvalid),
    .S_AXI_WREADY (wready),
    .S_AXI_BRESP  (bresp),
    .S_AXI_BVALID (bvalid),
    .S_AXI_BREADY (bready),
    .S_AXI_ARADDR (araddr),
    .S_AXI_ARPROT (arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA  (rdata),
    .S_AXI_RRESP  (rresp),
    .S_AXI_RVALID (rvalid),
    .S_AXI_RREADY (rready),
    .led_out      (led)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_write(input logic [5:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb);
    int w;
    w = int'(addr[5:2]);
    if (w < 4) begin
      for (int b = 0; b < 4; b++) if (strb[b]) model[w][8*b +: 8] = data[8*b +: 8];
      if (w == 0) model[0][1] = 1'b0;
    end
  endfunction

  function automatic logic [1:0] exp_resp(input logic [5:0] addr);
    return (addr[5:2] < 4'd4) ? RESP_OKAY : RESP_SLVERR;
  endfunction

  // Drive AW (optionally aw_lead cycles ahead of W); returns just after the commit edge
  task automatic aw_w(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input int aw_lead);
    int n;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = (aw_lead == 0);
    for (int i = 0; i < aw_lead; i++) begin
      #1;
      check("aw_alone_awready", awready, 0);
      check("aw_alone_wready", wready, 0);
      @(negedge clk);
    end
    wvalid = 1'b1;
    #1;
    n = 0;
    while (!awready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("aw_w_handshake", {awready, wready}, 2'b11);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    #1;
    check("bvalid_latency", bvalid, 1);
  endtask

  task automatic b_take(input int hold, input logic [1:0] exp);
    check("bresp", bresp, exp);
    bready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      check("bvalid_hold", bvalid, 1);
      check("bresp_hold", bresp, exp);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    #1;
    check("bvalid_drop", bvalid, 0);
  endtask

  task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
    aw_w(addr, data, strb, 0);
    b_take(0, exp_resp(addr));
    model_write(addr, data, strb);
  endtask

  task automatic do_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("ar_handshake", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    #1;
    check("rvalid_latency", rvalid, 1);
    data = rdata; resp = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    #1;
    check("rvalid_drop", rvalid, 0);
  endtask

  task automatic check_read(input logic [5:0] addr, input string tag);
    logic [31:0] d;
    logic [1:0]  r;
    do_read(addr, d, r);
    check(tag, d, (addr[5:2] < 4'd4) ? model[addr[5:2]] : 32'h0);
    check({tag, "_resp"}, r, exp_resp(addr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic [5:0]  a;

    rst = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    for (int i = 0; i < 4; i++) model[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_readies", {awready, wready, arready}, 3'b000);
    check("rst_valids", {bvalid, rvalid}, 2'b00);
    check("rst_resps", {bresp, rresp}, 4'b0000);
    check("rst_rdata", rdata, 32'h0);
    check("rst_led", led, 4'h0);
    rst = 1'b0;

    // Toggle engine: PERIOD=4, PATTERN=F, then enable
    do_write(6'h04, 32'd4, 4'hF);
    do_write(6'h08, 32'hF, 4'hF);
    aw_w(6'h00, 32'h1, 4'hF, 0);
    b_take(0, RESP_OKAY);
    model_write(6'h00, 32'h1, 4'hF);
    repeat (2) @(negedge clk);
    check("led_cycle3", led, 4'h0);
    @(negedge clk);
    check("led_cycle4", led, 4'hF);
    repeat (3) @(negedge clk);
    check("led_cycle7", led, 4'hF);
    @(negedge clk);
    check("led_cycle8", led, 4'h0);
    repeat (4) @(negedge clk);
    check("led_cycle12", led, 4'hF);

    // Clear wins in its commit cycle; B held off for 10 cycles
    aw_w(6'h00, 32'h3, 4'hF, 0);
    check("led_clear", led, 4'h0);
    b_take(10, RESP_OKAY);
    model_write(6'h00, 32'h3, 4'hF);
    check_read(6'h00, "ctrl_clear_reads0");

    // AW arrives 3 cycles before W
    aw_w(6'h0C, 32'h5A5A_0001, 4'hF, 3);
    b_take(0, RESP_OKAY);
    model_write(6'h0C, 32'h5A5A_0001, 4'hF);
    check_read(6'h0C, "aw_lead_single_commit");

    // Sequential writes then readback
    for (int i = 0; i < 4; i++) do_write(6'(i * 4), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) begin
      do_read(6'(i * 4), d, r);
      check("seq_readback", d, 32'(i + 1));
      check("seq_resp", r, RESP_OKAY);
    end

    // Byte strobes
    do_write(6'h0C, 32'h1122_3344, 4'hF);
    do_write(6'h0C, 32'hAABB_CCDD, 4'b0101);
    do_read(6'h0F, d, r);
    check("strobe_merge", d, 32'h11BB_33DD);

    // Unmapped space
    do_write(6'h20, 32'hDEAD_BEEF, 4'hF);
    do_read(6'h20, d, r);
    check("unmapped_rdata", d, 32'h0);
    check("unmapped_rresp", r, RESP_SLVERR);
    for (int i = 0; i < 4; i++) check_read(6'(i * 4), "unmapped_no_effect");

    // Randomized accesses against the register-map model
    for (int i = 0; i < 60; i++) begin
      a = {4'($urandom_range(0, 5)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)));
      else
        check_read(a, "rand_read");
    end

    // Reset with a read response pending
    @(negedge clk);
    araddr = 6'h08; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    #1;
    check("pending_rvalid", rvalid, 1);
    rst = 1'b1;
    #1;
    check("rst_drops_rvalid", rvalid, 0);
    check("rst_clears_led", led, 4'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = '0;
    for (int i = 0; i < 4; i++) check_read(6'(i * 4), "post_reset_reg");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
